// File: rtl/snn_pkg.sv
// Shared types and constants for the spike weight accumulator.
package snn_pkg;

  localparam int WEIGHT_W_DEFAULT = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } acc_state_t;

  localparam logic [WEIGHT_W_DEFAULT-1:0] SAT_MAX = {1'b0, {(WEIGHT_W_DEFAULT-1){1'b1}}};
  localparam logic [WEIGHT_W_DEFAULT-1:0] SAT_MIN = {1'b1, {(WEIGHT_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/snn_sat_add.sv
// Combinational signed adder; SPIKE_ACC_SATURATE_EN selects clamping instead of wrap-around.
module snn_sat_add
  import snn_pkg::*;
#(
  parameter int W = WEIGHT_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] raw;

`ifdef SPIKE_ACC_SATURATE_EN
  logic ovf;

  always_comb begin
    raw = a + b;
    // overflow only when both operands share a sign the result lost
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    if (ovf) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = raw;
    end
  end
`else
  always_comb begin
    raw = a + b;
    sum = raw;
  end
`endif

endmodule

// File: rtl/spike_weight_accumulator.sv
// Per-neuron spike weight accumulator: sums weights during ACCUM, streams and clears in DRAIN.
// Overflow behaviour is chosen by SPIKE_ACC_SATURATE_EN (see snn_sat_add).
module spike_weight_accumulator
  import snn_pkg::*;
#(
  parameter  int NEURON_COUNT = 32,
  parameter  int WEIGHT_W     = WEIGHT_W_DEFAULT,
  localparam int IDX_W        = $clog2(NEURON_COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spike_valid,
  output logic                spike_ready,
  input  logic [IDX_W-1:0]    spike_neuron_idx,
  input  logic [WEIGHT_W-1:0] spike_weight,
  input  logic                timestep_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_neuron_idx,
  output logic [WEIGHT_W-1:0] out_input_weight,
  output logic                busy,
  output logic                drain_done
);

  acc_state_t          state;
  logic [IDX_W-1:0]    k;
  logic [WEIGHT_W-1:0] acc [NEURON_COUNT];

  logic [31:0]         idx_ext;
  logic                in_range;
  logic [IDX_W-1:0]    rd_idx;
  logic [WEIGHT_W-1:0] add_sum;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [WEIGHT_W-1:0] wr_data;

  always_comb begin
    idx_ext  = 32'(spike_neuron_idx);
    in_range = idx_ext < 32'(NEURON_COUNT);
    rd_idx   = in_range ? spike_neuron_idx : '0;
  end

  snn_sat_add #(.W(WEIGHT_W)) u_add (
    .a   (acc[rd_idx]),
    .b   (spike_weight),
    .sum (add_sum)
  );

  // Single write port: spike adds in ACCUM, clear-on-handoff in DRAIN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (state == ACCUM) begin
      wr_en   = spike_valid && in_range;
      wr_idx  = spike_neuron_idx;
      wr_data = add_sum;
    end else begin
      wr_en   = out_ready;
      wr_idx  = k;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      k          <= '0;
      drain_done <= 1'b0;
      for (int unsigned i = 0; i < NEURON_COUNT; i++) begin
        acc[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      if (wr_en) begin
        acc[wr_idx] <= wr_data;
      end
      case (state)
        ACCUM: begin
          if (timestep_done) begin
            state <= DRAIN;
            k     <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (k == IDX_W'(NEURON_COUNT - 1)) begin
              state      <= ACCUM;
              k          <= '0;
              drain_done <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  always_comb begin
    busy             = (state == DRAIN);
    spike_ready      = !busy;
    out_valid        = busy;
    out_neuron_idx   = k;
    out_input_weight = busy ? acc[k] : '0;
  end

endmodule

// File: tb/tb_spike_weight_accumulator.sv
// Scoreboard bench for spike_weight_accumulator (32-neuron and 24-neuron instances).
module tb_spike_weight_accumulator;
  import snn_pkg::*;

  localparam int N  = 32;
  localparam int N2 = 24;
  localparam int W  = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          spike_valid, spike_ready, timestep_done;
  logic [IW-1:0] spike_neuron_idx;
  logic [W-1:0]  spike_weight;
  logic          out_valid, out_ready, busy, drain_done;
  logic [IW-1:0] out_neuron_idx;
  logic [W-1:0]  out_input_weight;

  logic          spike_valid_b, spike_ready_b, timestep_done_b;
  logic [IW-1:0] spike_neuron_idx_b;
  logic [W-1:0]  spike_weight_b;
  logic          out_valid_b, out_ready_b, busy_b, drain_done_b;
  logic [IW-1:0] out_neuron_idx_b;
  logic [W-1:0]  out_input_weight_b;

  spike_weight_accumulator #(.NEURON_COUNT(N), .WEIGHT_W(W)) dut (
    .clk(clk), .rst(rst),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_neuron_idx(spike_neuron_idx), .spike_weight(spike_weight),
    .timestep_done(timestep_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neuron_idx(out_neuron_idx), .out_input_weight(out_input_weight),
    .busy(busy), .drain_done(drain_done)
  );

  spike_weight_accumulator #(.NEURON_COUNT(N2), .WEIGHT_W(W)) dut24 (
    .clk(clk), .rst(rst),
    .spike_valid(spike_valid_b), .spike_ready(spike_ready_b),
    .spike_neuron_idx(spike_neuron_idx_b), .spike_weight(spike_weight_b),
    .timestep_done(timestep_done_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_neuron_idx(out_neuron_idx_b), .out_input_weight(out_input_weight_b),
    .busy(busy_b), .drain_done(drain_done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] w;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [N];

  function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef SPIKE_ACC_SATURATE_EN
    if (s > longint'(signed'(SAT_MAX))) return SAT_MAX;
    if (s < longint'(signed'(SAT_MIN))) return SAT_MIN;
`endif
    return s[W-1:0];
  endfunction

  task automatic send_spike(input int idx, input logic [W-1:0] w);
    @(negedge clk);
    spike_valid      = 1'b1;
    spike_neuron_idx = idx[IW-1:0];
    spike_weight     = w;
    n_checks++;
    if (spike_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL spike_ready_accum: got %b want 1", spike_ready);
    end
    if (idx < N) model[idx] = model_add(model[idx], w);
    @(posedge clk);
    #1 spike_valid = 1'b0;
  endtask

  task automatic close_ts(input bit with_spike, input int idx, input logic [W-1:0] w);
    @(negedge clk);
    timestep_done = 1'b1;
    if (with_spike) begin
      spike_valid      = 1'b1;
      spike_neuron_idx = idx[IW-1:0];
      spike_weight     = w;
      if (idx < N) model[idx] = model_add(model[idx], w);
    end
    for (int i = 0; i < N; i++) begin
      sb.push_back('{idx: i, w: model[i]});
      model[i] = '0;
    end
    @(posedge clk);
    #1;
    timestep_done = 1'b0;
    spike_valid   = 1'b0;
  endtask

  task automatic run_drain(input bit toggle, input string name);
    int  outs;
    int  done_cyc;
    bit  done;
    bit  rdy;
    outs = 0;
    done = 1'b0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      timestep_done = toggle && (cyc == 5);
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: idx %0d beyond expected drain", name, out_neuron_idx);
        end else if (out_neuron_idx !== IW'(sb[0].idx) || out_input_weight !== sb[0].w) begin
          n_fail++;
          $display("FAIL %s_data: got idx %0d w %h want idx %0d w %h", name,
                   out_neuron_idx, out_input_weight, sb[0].idx, sb[0].w);
        end
        n_checks++;
        if (spike_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_busy: got spike_ready %b busy %b want 0 1", name, spike_ready, busy);
        end
        rdy = toggle ? (cyc % 2 == 0) : 1'b1;
        out_ready = rdy;
        if (rdy && sb.size() > 0) begin
          void'(sb.pop_front());
          outs++;
        end
      end else if (drain_done === 1'b1) begin
        done = 1'b1;
        done_cyc = cyc;
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_stall: got out_valid 0 drain_done 0 at cycle %0d", name, cyc);
        done = 1'b1;
      end
    end
    out_ready     = 1'b0;
    timestep_done = 1'b0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no drain_done want pulse", name);
    end else begin
      n_checks++;
      if (done_cyc != (toggle ? 2*N-1 : N) || outs != N) begin
        n_fail++;
        $display("FAIL %s_length: got done at %0d after %0d outputs want %0d after %0d",
                 name, done_cyc, outs, toggle ? 2*N-1 : N, N);
      end
      if (busy !== 1'b0 || spike_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_end: got busy %b spike_ready %b want 0 1", name, busy, spike_ready);
      end
      @(negedge clk);
      n_checks++;
      if (drain_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_pulse: got drain_done %b want 0", name, drain_done);
      end
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({spike_ready, out_valid, out_neuron_idx, out_input_weight, busy, drain_done} !==
        {1'b1, 1'b0, {IW{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy %b vld %b idx %0d w %h busy %b dd %b want 1 0 0 0 0 0",
               spike_ready, out_valid, out_neuron_idx, out_input_weight, busy, drain_done);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic test_basic();
    send_spike(5, 32'd10);
    send_spike(5, 32'd20);
    send_spike(5, -32'sd5);
    close_ts(1'b0, 0, '0);
    run_drain(1'b0, "basic");
  endtask

  task automatic test_closing_spike();
    send_spike(3, 32'd100);
    close_ts(1'b1, 0, 32'd7);
    run_drain(1'b0, "closing");
    close_ts(1'b0, 0, '0);
    run_drain(1'b0, "cleared");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) send_spike(i * 4 + 1, 32'(i * 3 + 1));
    send_spike(31, 32'hDEAD_BEEF);
    close_ts(1'b0, 0, '0);
    run_drain(1'b1, "backpressure");
  endtask

  task automatic test_overflow();
    send_spike(1, 32'h7FFF_FFFF);
    send_spike(1, 32'h7FFF_FFFF);
    send_spike(2, 32'h8000_0000);
    send_spike(2, 32'hFFFF_FFFF);
    close_ts(1'b0, 0, '0);
    run_drain(1'b0, "overflow");
  endtask

  task automatic test_reset_mid_drain();
    bit hit;
    hit = 1'b0;
    send_spike(12, 32'd55);
    close_ts(1'b0, 0, '0);
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid === 1'b1 && out_neuron_idx === IW'(10)) begin
        rst = 1'b1;
        hit = 1'b1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midreset_reach: got no idx 10 want idx 10");
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || spike_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got out_valid %b spike_ready %b want 0 1", out_valid, spike_ready);
    end
    rst       = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) model[i] = '0;
    close_ts(1'b0, 0, '0);
    run_drain(1'b0, "midreset_zero");
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    spike_valid_b      = 1'b1;
    spike_neuron_idx_b = IW'(30);
    spike_weight_b     = 32'd123;
    n_checks++;
    if (spike_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready: got %b want 1", spike_ready_b);
    end
    @(posedge clk);
    #1 spike_valid_b = 1'b0;
    @(negedge clk);
    timestep_done_b = 1'b1;
    @(posedge clk);
    #1 timestep_done_b = 1'b0;
    for (int i = 0; i < N2; i++) begin
      @(negedge clk);
      out_ready_b = 1'b1;
      n_checks++;
      if (out_valid_b !== 1'b1 || out_neuron_idx_b !== IW'(i) || out_input_weight_b !== '0) begin
        n_fail++;
        $display("FAIL oor_data: got vld %b idx %0d w %h want 1 %0d 0",
                 out_valid_b, out_neuron_idx_b, out_input_weight_b, i);
      end
    end
    @(negedge clk);
    out_ready_b = 1'b0;
    n_checks++;
    if (drain_done_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_done: got drain_done %b busy %b want 1 0", drain_done_b, busy_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    spike_valid = 1'b0; spike_neuron_idx = '0; spike_weight = '0;
    timestep_done = 1'b0; out_ready = 1'b0;
    spike_valid_b = 1'b0; spike_neuron_idx_b = '0; spike_weight_b = '0;
    timestep_done_b = 1'b0; out_ready_b = 1'b0;

    test_reset();
    test_basic();
    test_closing_spike();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_out_of_range();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
